// File: rtl/mux_row_scheduler_if.sv
// Framebuffer fetch / driver shift handshake between the row scheduler and the slice framebuffer.
interface mux_row_scheduler_if #(
    parameter int unsigned LED_WIDTH = 4
);
    logic [3:0]           load_row_en;
    logic [LED_WIDTH-1:0] led;
    logic                 data_req;
    logic                 data_ack;
    logic                 shift_en;

    modport master (output load_row_en, led, data_req, shift_en, input data_ack);
    modport slave  (input load_row_en, led, data_req, shift_en, output data_ack);
endinterface

// File: rtl/mux_row_scheduler.sv
// Runs one multiplexing frame: per row fetch/shift all driver outputs, blank, latch, then display.
module mux_row_scheduler #(
    parameter int unsigned NB_LEDS_PER_GROUP = 16,
    parameter int unsigned BLANK_CYCLES      = 4,
    parameter int unsigned ON_CYCLES         = 64
) (
    input  logic                      clk,
    input  logic                      nrst,
    input  logic                      start_frame,
    mux_row_scheduler_if.master       bus,
    output logic                      latch,
    output logic [3:0]                row_en,
    output logic                      busy,
    output logic                      frame_done
);
    localparam int unsigned LED_WIDTH = $clog2(NB_LEDS_PER_GROUP);
    localparam int unsigned MAX_CYC   = (BLANK_CYCLES > ON_CYCLES) ? BLANK_CYCLES : ON_CYCLES;
    localparam int unsigned CNT_WIDTH = $clog2(MAX_CYC + 1);

    localparam logic [LED_WIDTH-1:0] LED_LAST   = LED_WIDTH'(NB_LEDS_PER_GROUP - 1);
    localparam logic [CNT_WIDTH-1:0] BLANK_LAST = CNT_WIDTH'(BLANK_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] ON_LAST    = CNT_WIDTH'(ON_CYCLES - 1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] LOAD    = 3'd1;
    localparam logic [2:0] BLANK   = 3'd2;
    localparam logic [2:0] LATCH   = 3'd3;
    localparam logic [2:0] DISPLAY = 3'd4;

    logic [2:0]           state, state_n;
    logic [1:0]           row, row_n;
    logic [LED_WIDTH-1:0] led_q, led_n;
    logic [CNT_WIDTH-1:0] cnt, cnt_n;

    logic [3:0] load_row_en_q, load_row_en_n;
    logic       data_req_q, data_req_n;
    logic       latch_n;
    logic [3:0] row_en_n;
    logic       busy_n;
    logic       frame_done_n;

    // Next-state and next-output decode; outputs are registered from the next state.
    always_comb begin
        state_n      = state;
        row_n        = row;
        led_n        = led_q;
        cnt_n        = cnt;
        frame_done_n = 1'b0;

        case (state)
            IDLE: begin
                if (start_frame) begin
                    state_n = LOAD;
                    row_n   = 2'd0;
                    led_n   = '0;
                end
            end
            LOAD: begin
                if (bus.data_ack) begin
                    if (led_q == LED_LAST) begin
                        state_n = BLANK;
                        led_n   = '0;
                        cnt_n   = '0;
                    end else begin
                        led_n = led_q + 1'b1;
                    end
                end
            end
            BLANK: begin
                if (cnt == BLANK_LAST) begin
                    state_n = LATCH;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            LATCH: begin
                state_n = DISPLAY;
                cnt_n   = '0;
            end
            DISPLAY: begin
                if (cnt == ON_LAST) begin
                    cnt_n = '0;
                    led_n = '0;
                    if (row == 2'd3) begin
                        state_n      = IDLE;
                        row_n        = 2'd0;
                        frame_done_n = 1'b1;
                    end else begin
                        state_n = LOAD;
                        row_n   = row + 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                row_n   = 2'd0;
                led_n   = '0;
                cnt_n   = '0;
            end
        endcase

        load_row_en_n = (state_n == LOAD)    ? (4'b0001 << row_n) : 4'b0000;
        row_en_n      = (state_n == DISPLAY) ? (4'b0001 << row_n) : 4'b0000;
        data_req_n    = (state_n == LOAD);
        latch_n       = (state_n == LATCH);
        busy_n        = (state_n != IDLE);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state         <= IDLE;
            row           <= 2'd0;
            led_q         <= '0;
            cnt           <= '0;
            load_row_en_q <= 4'b0000;
            data_req_q    <= 1'b0;
            latch         <= 1'b0;
            row_en        <= 4'b0000;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            state         <= state_n;
            row           <= row_n;
            led_q         <= led_n;
            cnt           <= cnt_n;
            load_row_en_q <= load_row_en_n;
            data_req_q    <= data_req_n;
            latch         <= latch_n;
            row_en        <= row_en_n;
            busy          <= busy_n;
            frame_done    <= frame_done_n;
        end
    end

    // Shift strobe is the only combinational output: an accepted transfer this cycle.
    assign bus.load_row_en = load_row_en_q;
    assign bus.led         = led_q;
    assign bus.data_req    = data_req_q;
    assign bus.shift_en    = data_req_q & bus.data_ack;

endmodule

// File: tb/tb_mux_row_scheduler.sv
// Bench for mux_row_scheduler: default and minimal configurations against a frame-schedule model.
module tb_mux_row_scheduler;

    logic clk = 1'b0;
    logic nrst;
    logic start [2];
    logic ack   [2];
    int   cyc = 0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mux_row_scheduler_if #(.LED_WIDTH(4)) bus0 ();
    mux_row_scheduler_if #(.LED_WIDTH(2)) bus1 ();

    logic       latch0, latch1, busy0, busy1, done0, done1;
    logic [3:0] ren0, ren1;

    mux_row_scheduler #(.NB_LEDS_PER_GROUP(16), .BLANK_CYCLES(4), .ON_CYCLES(64)) dut0 (
        .clk(clk), .nrst(nrst), .start_frame(start[0]), .bus(bus0),
        .latch(latch0), .row_en(ren0), .busy(busy0), .frame_done(done0));

    mux_row_scheduler #(.NB_LEDS_PER_GROUP(4), .BLANK_CYCLES(1), .ON_CYCLES(1)) dut1 (
        .clk(clk), .nrst(nrst), .start_frame(start[1]), .bus(bus1),
        .latch(latch1), .row_en(ren1), .busy(busy1), .frame_done(done1));

    assign bus0.data_ack = ack[0];
    assign bus1.data_ack = ack[1];

    // {load_row_en[16:13], led[12:9], data_req[8], shift_en[7], latch[6], row_en[5:2], busy[1], frame_done[0]}
    logic [16:0] act [2];
    assign act[0] = {bus0.load_row_en, bus0.led, bus0.data_req, bus0.shift_en, latch0, ren0, busy0, done0};
    assign act[1] = {bus1.load_row_en, {2'b00, bus1.led}, bus1.data_req, bus1.shift_en, latch1, ren1, busy1, done1};

    function automatic int p_n(int i);  return (i == 0) ? 16 : 4; endfunction
    function automatic int p_b(int i);  return (i == 0) ? 4  : 1; endfunction
    function automatic int p_on(int i); return (i == 0) ? 64 : 1; endfunction

    // Model: a row is "acks accepted so far" then "cycles elapsed since the last ack".
    bit m_active [2];
    int m_row    [2];
    int m_acks   [2];
    int m_t      [2];
    bit m_done   [2];

    always @(posedge clk or negedge nrst) begin
        for (int i = 0; i < 2; i++) begin
            if (!nrst) begin
                m_active[i] = 1'b0; m_row[i] = 0; m_acks[i] = 0; m_t[i] = 0; m_done[i] = 1'b0;
            end else if (!m_active[i]) begin
                m_done[i] = 1'b0;
                if (start[i]) begin
                    m_active[i] = 1'b1; m_row[i] = 0; m_acks[i] = 0; m_t[i] = 0;
                end
            end else begin
                m_done[i] = 1'b0;
                if (m_acks[i] < p_n(i)) begin
                    if (ack[i]) m_acks[i]++;
                end else if (m_t[i] == p_b(i) + p_on(i)) begin
                    if (m_row[i] == 3) begin
                        m_active[i] = 1'b0;
                        m_done[i]   = 1'b1;
                    end else begin
                        m_row[i]++; m_acks[i] = 0; m_t[i] = 0;
                    end
                end else begin
                    m_t[i]++;
                end
            end
        end
    end

    function automatic logic [16:0] expv(int i);
        logic [3:0] lre = 4'd0, ld = 4'd0, ren = 4'd0;
        logic req = 1'b0, sh = 1'b0, la = 1'b0;
        if (m_active[i]) begin
            if (m_acks[i] < p_n(i)) begin
                lre = 4'(1 << m_row[i]);
                ld  = 4'(m_acks[i]);
                req = 1'b1;
                sh  = ack[i];
            end else if (m_t[i] == p_b(i)) begin
                la = 1'b1;
            end else if (m_t[i] > p_b(i)) begin
                ren = 4'(1 << m_row[i]);
            end
        end
        return {lre, ld, req, sh, la, ren, m_active[i], m_done[i]};
    endfunction

    int first_latch [2];
    int latch_cnt   [2];
    int done_cnt    [2];
    int done_label  [2];

    // Per-cycle compare plus event monitor; cycle label = edges seen + 1.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic [16:0] e;
            e = expv(i);
            checks++;
            if (act[i] !== e) begin
                errors++;
                $display("FAIL cycle%0d dut%0d outputs act=%h exp=%h", cyc + 1, i, act[i], e);
            end
            checks++;
            if (!$onehot0(act[i][5:2]) || ((act[i][5:2] & act[i][16:13]) != 4'd0)) begin
                errors++;
                $display("FAIL cycle%0d dut%0d row_exclusive row_en=%b load_row_en=%b", cyc + 1, i,
                         act[i][5:2], act[i][16:13]);
            end
            if (act[i][6] === 1'b1) begin
                latch_cnt[i]++;
                if (first_latch[i] < 0) first_latch[i] = cyc + 1;
            end
            if (act[i][0] === 1'b1) begin
                done_cnt[i]++;
                done_label[i] = cyc + 1;
            end
        end
    end

    task automatic chk(input string name, input int a, input int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d", name, a, e);
        end
    endtask

    task automatic clear_mon();
        for (int i = 0; i < 2; i++) begin
            first_latch[i] = -1; latch_cnt[i] = 0; done_cnt[i] = 0; done_label[i] = -1;
        end
    endtask

    task automatic step(input int i, input bit st, input bit ak);
        @(posedge clk);
        #1;
        start[i] = st;
        ack[i]   = ak;
    endtask

    task automatic run_random(input int i, input int want_done, input string name);
        int n = 0;
        while (done_cnt[i] < want_done && n < 3000) begin
            logic b;
            b = (i == 0) ? busy0 : busy1;
            step(i, ($urandom % 16 == 0) && b, ($urandom % 4) != 0);
            n++;
        end
        step(i, 1'b0, 1'b0);
        chk(name, done_cnt[i], want_done);
    endtask

    initial begin
        int t;
        nrst = 1'b0;
        start[0] = 1'b0; start[1] = 1'b0;
        ack[0] = 1'b0; ack[1] = 1'b0;
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs0", int'(act[0]), 0);
        chk("reset_outputs1", int'(act[1]), 0);
        #1 nrst = 1'b1;

        // Default config, ack always high
        clear_mon();
        step(0, 1'b1, 1'b1);
        t = cyc + 1;
        for (int k = 1; k <= 345; k++) begin
            step(0, 1'b0, 1'b1);
            if (k == 21)  begin #2; chk("t1_ren_before", int'(ren0), 0); end
            if (k == 22)  begin #2; chk("t1_ren_row0", int'(ren0), 1); end
            if (k == 107) begin #2; chk("t1_ren_row1", int'(ren0), 2); end
        end
        chk("t1_first_latch", first_latch[0] - t, 21);
        chk("t1_done_cycle", done_label[0] - t, 341);
        chk("t1_done_count", done_cnt[0], 1);
        chk("t1_latch_count", latch_cnt[0], 4);

        // Stall of 10 at row 2 led 7, ignored restart in row 1 display, restart with frame_done
        clear_mon();
        step(0, 1'b1, 1'b1);
        t = cyc + 1;
        for (int k = 1; k <= 351; k++) begin
            step(0, (k == 120) || (k == 351), !(k >= 178 && k <= 187));
            if (k == 183) begin
                #2;
                chk("stall_led", int'(bus0.led), 7);
                chk("stall_req", int'(bus0.data_req), 1);
                chk("stall_shift", int'(bus0.shift_en), 0);
            end
        end
        step(0, 1'b0, 1'b1);
        chk("t2_done_cycle", done_label[0] - t, 351);
        chk("t2_done_count", done_cnt[0], 1);
        chk("t2_busy_after_restart", int'(busy0), 1);
        run_random(0, 2, "t3_random_frame_done");
        repeat (3) step(0, 1'b0, 1'b0);
        chk("t3_idle", int'(busy0), 0);

        // Reset in the middle of row 2 display
        clear_mon();
        step(0, 1'b1, 1'b1);
        t = cyc + 1;
        for (int k = 1; k <= 200; k++) step(0, 1'b0, 1'b1);
        chk("pre_reset_ren", int'(ren0), 4);
        clear_mon();
        #2 nrst = 1'b0;
        #1;
        chk("mid_reset_outputs", int'(act[0]), 0);
        @(posedge clk);
        @(posedge clk);
        #1 nrst = 1'b1;
        for (int k = 0; k < 30; k++) step(0, 1'b0, 1'b1);
        chk("post_reset_latch", latch_cnt[0], 0);
        chk("post_reset_done", done_cnt[0], 0);
        chk("post_reset_busy", int'(busy0), 0);
        step(0, 1'b1, 1'b1);
        step(0, 1'b0, 1'b1);
        #2;
        chk("restart_row", int'(bus0.load_row_en), 1);
        chk("restart_led", int'(bus0.led), 0);
        run_random(0, 1, "t4_random_frame_done");

        // Minimal config: row period 7, frame 28
        clear_mon();
        step(1, 1'b1, 1'b1);
        t = cyc + 1;
        for (int k = 1; k <= 32; k++) step(1, 1'b0, 1'b1);
        chk("small_first_latch", first_latch[1] - t, 6);
        chk("small_done_cycle", done_label[1] - t, 29);
        chk("small_latch_count", latch_cnt[1], 4);
        clear_mon();
        step(1, 1'b1, 1'b1);
        run_random(1, 1, "small_random_frame_done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mux_row_scheduler.md
# mux_row_scheduler

Sequences one full multiplexing frame of an LED group: for each of the 4 mux rows it fetches greyscale data for every driver output, shifts it into the driver, blanks, latches, then enables that row for a fixed on-time. It sits between the slice framebuffer (data handshake) and the LED driver and row MOSFETs. It also feeds the row-height lookup with the row/output pair currently being loaded.

## Interface

Parameters:
- NB_LEDS_PER_GROUP, 16, driver outputs per group; LED_WIDTH = $clog2(NB_LEDS_PER_GROUP)
- BLANK_CYCLES, 4, row-off cycles before latch (>=1)
- ON_CYCLES, 64, cycles a row stays enabled (>=1)

Ports:
- clk  in  1  single clock domain
- nrst  in  1  asynchronous, active-low reset
- start_frame  in  1  one-cycle request to run a frame; honoured only in IDLE
- load_row_en  out  4  one-hot mux row whose data is being fetched; 0 outside LOAD
- led  out  LED_WIDTH  driver output index being fetched
- data_req  out  1  fetch request for (load_row_en, led)
- data_ack  in  1  framebuffer has data on the driver SIN path this cycle
- shift_en  out  1  driver shift strobe; combinational = data_req & data_ack
- latch  out  1  driver latch pulse
- row_en  out  4  one-hot row drive to MOSFETs; 0 except in DISPLAY
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse at frame end

## Operation

- States: IDLE, LOAD, BLANK, LATCH, DISPLAY. Registers: state, row (2 bits), led counter, cycle counter (width = $clog2(max(BLANK_CYCLES, ON_CYCLES)+1)).
- IDLE: all outputs 0. start_frame=1 -> LOAD, row=0, led=0.
- LOAD: data_req=1, load_row_en=1<<row. Each cycle with data_ack=1 is one accepted transfer: shift_en=1 that cycle, led increments. Ack on led=NB_LEDS_PER_GROUP-1 -> BLANK, led wraps to 0. data_ack=0 stalls indefinitely with no state change.
- BLANK: row_en=0 for exactly BLANK_CYCLES cycles -> LATCH.
- LATCH: latch=1 for exactly 1 cycle -> DISPLAY.
- DISPLAY: row_en=1<<row for exactly ON_CYCLES cycles. Then if row<3: row++, -> LOAD; if row==3: -> IDLE, frame_done=1 in the first IDLE cycle.
- start_frame outside IDLE is ignored (not queued). start_frame in the IDLE cycle carrying frame_done is accepted.
- data_ack outside LOAD is ignored; shift_en stays 0.
- row_en and load_row_en are never both nonzero; row_en is never multi-hot.

## Timing

- All outputs except shift_en are registered; shift_en is combinational from data_ack.
- Reset (nrst low, any time, including mid-LOAD or mid-DISPLAY): state=IDLE, row=0, led=0, counters=0. All outputs are 0 immediately; no latch or frame_done is emitted. Operation resumes only on a new start_frame after nrst is high.
- start_frame sampled at edge T: data_req=1 from cycle T+1.
- Per row with data_ack held high: NB_LEDS_PER_GROUP + BLANK_CYCLES + 1 + ON_CYCLES cycles. With defaults this is 85 cycles, or 340 cycles per frame.
- With defaults and ack always high, frame_done is high in cycle T+341 relative to start_frame at T.
- The first LOAD cycle of row r+1 immediately follows the last DISPLAY cycle of row r; there are no idle gaps.

## Test plan

- Defaults, data_ack tied 1, start_frame pulse at T:
  - Expect 16 shift_en pulses with led 0..15 and load_row_en=0001.
  - Then 4 blank cycles, latch at T+21, row_en=0001 for T+22..T+85.
  - Repeat for rows 0010, 0100, 1000; frame_done only at T+341.
- data_ack stalls:
  - Ack low for 10 cycles at led=7 of row 2 -> led holds at 7, data_req stays 1, no shift_en.
  - Frame length grows by exactly 10 cycles.
- start_frame re-pulsed during DISPLAY of row 1 -> ignored; exactly one frame_done. A pulse coincident with frame_done starts a second frame.
- nrst asserted mid-DISPLAY of row 2:
  - All outputs 0 at once, no latch, no frame_done.
  - After release, a new start_frame restarts at row 0, led 0.
- BLANK_CYCLES=1, ON_CYCLES=1, NB_LEDS_PER_GROUP=4, ack high:
  - Row period is 7 cycles, frame is 28 cycles.
  - Every cycle checks row_en one-hot or zero, and row_en & load_row_en = 0.
